// File: rtl/rf_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_scheduler_if
// Description : Bundle of the handshake and data signals around the shared
//               register-file write port. The master side drives decode,
//               writeback and LLU requests; the slave side is the scheduler.
//   i_wb_*     : pipeline writeback request (valid, rd, data)
//   i_llu_issue*, o_llu_issue_ready : LLU dispatch handshake
//   i_llu_*,   o_llu_ready          : LLU result handshake
//   i_id_*     : decode-stage operand/destination usage
//   o_stall, o_reg_write, o_rd, o_rd_din, o_sb_err : scheduler outputs
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_scheduler_if #(
  parameter int XLEN = 32
);
  logic            i_wb_reg_write;
  logic [4:0]      i_wb_rd;
  logic [XLEN-1:0] i_wb_din;
  logic            i_llu_issue;
  logic [4:0]      i_llu_issue_rd;
  logic            o_llu_issue_ready;
  logic            i_llu_valid;
  logic [4:0]      i_llu_rd;
  logic [XLEN-1:0] i_llu_din;
  logic            o_llu_ready;
  logic [4:0]      i_id_rs1;
  logic [4:0]      i_id_rs2;
  logic [4:0]      i_id_rd;
  logic            i_id_uses_rs1;
  logic            i_id_uses_rs2;
  logic            i_id_writes_rd;
  logic            o_stall;
  logic            o_reg_write;
  logic [4:0]      o_rd;
  logic [XLEN-1:0] o_rd_din;
  logic            o_sb_err;

  modport master (
    output i_wb_reg_write, i_wb_rd, i_wb_din,
    output i_llu_issue, i_llu_issue_rd,
    input  o_llu_issue_ready,
    output i_llu_valid, i_llu_rd, i_llu_din,
    input  o_llu_ready,
    output i_id_rs1, i_id_rs2, i_id_rd, i_id_uses_rs1, i_id_uses_rs2, i_id_writes_rd,
    input  o_stall, o_reg_write, o_rd, o_rd_din, o_sb_err
  );

  modport slave (
    input  i_wb_reg_write, i_wb_rd, i_wb_din,
    input  i_llu_issue, i_llu_issue_rd,
    output o_llu_issue_ready,
    input  i_llu_valid, i_llu_rd, i_llu_din,
    output o_llu_ready,
    input  i_id_rs1, i_id_rs2, i_id_rd, i_id_uses_rs1, i_id_uses_rs2, i_id_writes_rd,
    output o_stall, o_reg_write, o_rd, o_rd_din, o_sb_err
  );
endinterface
`default_nettype wire

// File: rtl/rf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_scheduler
// Description : Shares the single register-file write port between in-order
//               writeback and a long-latency unit. A pending scoreboard
//               stalls decode on RAW/WAW hazards; LLU results wait in a small
//               FIFO and drain whenever writeback leaves the port idle.
// Ports       : i_clk  - clock, rising edge
//               i_rst  - asynchronous active-high reset
//               bus    - rf_write_scheduler_if.slave (writeback, LLU issue,
//                        LLU result, decode hazard query, write port, error)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_scheduler #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input wire logic            i_clk,
  input wire logic            i_rst,
  rf_write_scheduler_if.slave bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [31:0]     pending_q, pending_d;
  logic [AW:0]     count_q, count_d;   // outstanding LLU ops
  logic [AW:0]     fill_q, fill_d;     // FIFO occupancy
  logic [AW-1:0]   wptr_q, rptr_q;
  logic            sb_err_q, sb_err_d;
  logic [4:0]      mem_rd_q  [DEPTH];
  logic [XLEN-1:0] mem_din_q [DEPTH];

  logic            w_wb_active, w_fifo_full, w_fifo_empty;
  logic            w_issue_ready, w_llu_ready, w_issue_acc;
  logic            w_push, w_pop, w_head_write;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_din;
  logic [31:0]     w_clr_mask, w_set_mask, w_pend_eff;

  // Writeback to x0 is treated as an idle port so the FIFO may drain.
  assign w_wb_active   = !i_rst && bus.i_wb_reg_write && (bus.i_wb_rd != 5'd0);
  assign w_fifo_empty  = (fill_q == '0);
  assign w_fifo_full   = (fill_q == C_DEPTH);
  assign w_issue_ready = !i_rst && (count_q < C_DEPTH);
  assign w_llu_ready   = !i_rst && !w_fifo_full;
  assign w_issue_acc   = bus.i_llu_issue && w_issue_ready;
  // Push acceptance uses the pre-pop full flag even when a pop frees a slot.
  assign w_push        = bus.i_llu_valid && w_llu_ready;
  // Occupancy is registered, so an entry is poppable one cycle after push.
  assign w_pop         = !i_rst && !w_wb_active && !w_fifo_empty;
  assign w_head_rd     = mem_rd_q[rptr_q];
  assign w_head_din    = mem_din_q[rptr_q];
  assign w_head_write  = w_pop && (w_head_rd != 5'd0);

  assign w_clr_mask = w_head_write ? (32'd1 << w_head_rd) : 32'd0;
  assign w_set_mask = (w_issue_acc && (bus.i_llu_issue_rd != 5'd0)) ?
                      (32'd1 << bus.i_llu_issue_rd) : 32'd0;
  // Clear is applied combinationally so decode sees the hazard drop in the
  // same cycle the result is written (register file writes through).
  assign w_pend_eff = pending_q & ~w_clr_mask;
  // Set is OR-ed last so it wins over a same-cycle clear.
  assign pending_d  = w_pend_eff | w_set_mask;
  assign sb_err_d   = sb_err_q |
                      (w_push && (bus.i_llu_rd != 5'd0) && !pending_q[bus.i_llu_rd]);

  always_comb begin
    count_d = count_q;
    if (w_issue_acc && !w_pop) begin
      count_d = count_q + C_ONE;
    end else if (!w_issue_acc && w_pop) begin
      count_d = count_q - C_ONE;
    end
  end

  always_comb begin
    fill_d = fill_q;
    if (w_push && !w_pop) begin
      fill_d = fill_q + C_ONE;
    end else if (!w_push && w_pop) begin
      fill_d = fill_q - C_ONE;
    end
  end

  assign bus.o_llu_issue_ready = w_issue_ready;
  assign bus.o_llu_ready       = w_llu_ready;
  assign bus.o_reg_write       = w_wb_active || w_head_write;
  assign bus.o_rd              = w_wb_active ? bus.i_wb_rd  : (w_pop ? w_head_rd  : 5'd0);
  assign bus.o_rd_din          = w_wb_active ? bus.i_wb_din : (w_pop ? w_head_din : '0);
  assign bus.o_sb_err          = sb_err_q;
  // A full FIFO stalls decode to inject writeback bubbles and avoid starvation.
  assign bus.o_stall = i_rst
                    || (bus.i_id_uses_rs1  && w_pend_eff[bus.i_id_rs1])
                    || (bus.i_id_uses_rs2  && w_pend_eff[bus.i_id_rs2])
                    || (bus.i_id_writes_rd && w_pend_eff[bus.i_id_rd])
                    || (bus.i_llu_issue && !w_issue_ready)
                    || w_fifo_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= '0;
      count_q   <= '0;
      fill_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      fill_q    <= fill_d;
      sb_err_q  <= sb_err_d;
      if (w_push) begin
        wptr_q <= wptr_q + C_PTR_ONE;
      end
      if (w_pop) begin
        rptr_q <= rptr_q + C_PTR_ONE;
      end
    end
  end

  // Storage needs no reset: entries are only observed while occupancy is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_rd_q[wptr_q]  <= bus.i_llu_rd;
      mem_din_q[wptr_q] <= bus.i_llu_din;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_scheduler
// Description : Directed bench for rf_write_scheduler. Expected register-file
//               writes are queued as stimulus is applied; a monitor pops and
//               compares on every cycle the DUT asserts o_reg_write. Status
//               outputs (stall, ready, error) are compared inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_scheduler;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] din;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;

  always #5 clk = ~clk;

  rf_write_scheduler_if #(.XLEN(XLEN)) bus ();

  rf_write_scheduler #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [XLEN-1:0] din);
    wr_t e;
    e.rd  = rd;
    e.din = din;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.i_wb_reg_write = 1'b0; bus.i_wb_rd = '0; bus.i_wb_din = '0;
    bus.i_llu_issue = 1'b0; bus.i_llu_issue_rd = '0;
    bus.i_llu_valid = 1'b0; bus.i_llu_rd = '0; bus.i_llu_din = '0;
    bus.i_id_rs1 = '0; bus.i_id_rs2 = '0; bus.i_id_rd = '0;
    bus.i_id_uses_rs1 = 1'b0; bus.i_id_uses_rs2 = 1'b0; bus.i_id_writes_rd = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Write-port monitor: every DUT write must match the head of the queue.
  always @(negedge clk) begin
    if (bus.o_reg_write === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got rd=%0d din=%08h required no write", bus.o_rd, bus.o_rd_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.o_rd !== mon_e.rd || bus.o_rd_din !== mon_e.din) begin
          bad++;
          $display("FAIL wr_data: got rd=%0d din=%08h required rd=%0d din=%08h",
                   bus.o_rd, bus.o_rd_din, mon_e.rd, mon_e.din);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs forced even with writeback requesting.
    idle();
    rst = 1'b1;
    bus.i_wb_reg_write = 1'b1; bus.i_wb_rd = 5'd3; bus.i_wb_din = 32'h1234;
    mid();
    chk("rst_reg_write", 32'(bus.o_reg_write), 32'd0);
    chk("rst_rd", 32'(bus.o_rd), 32'd0);
    chk("rst_stall", 32'(bus.o_stall), 32'd1);
    chk("rst_issue_ready", 32'(bus.o_llu_issue_ready), 32'd0);
    chk("rst_llu_ready", 32'(bus.o_llu_ready), 32'd0);
    nxt(); nxt();
    idle(); rst = 1'b0;
    mid();
    chk("post_rst_stall", 32'(bus.o_stall), 32'd0);
    chk("post_rst_issue_ready", 32'(bus.o_llu_issue_ready), 32'd1);
    chk("post_rst_sb_err", 32'(bus.o_sb_err), 32'd0);
    nxt();

    // RAW on rd=5 and same-cycle bypass on drain.
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd5;
    nxt();
    bus.i_llu_issue = 1'b0; bus.i_id_uses_rs1 = 1'b1; bus.i_id_rs1 = 5'd5;
    mid(); chk("raw_stall", 32'(bus.o_stall), 32'd1); nxt();
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd5; bus.i_llu_din = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    mid(); chk("raw_stall_buffered", 32'(bus.o_stall), 32'd1); nxt();
    bus.i_llu_valid = 1'b0;
    mid();
    chk("bypass_stall", 32'(bus.o_stall), 32'd0);
    chk("bypass_we", 32'(bus.o_reg_write), 32'd1);
    nxt();
    idle();
    mid(); chk("t1_issue_ready", 32'(bus.o_llu_issue_ready), 32'd1); nxt();

    // Result for rd=7 held while writeback owns the port for 3 cycles.
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd7;
    nxt();
    bus.i_llu_issue = 1'b0;
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd7; bus.i_llu_din = 32'h7777;
    bus.i_wb_reg_write = 1'b1; bus.i_wb_rd = 5'd3; bus.i_wb_din = 32'h33;
    expect_wr(5'd3, 32'h33);
    nxt();
    bus.i_llu_valid = 1'b0; bus.i_wb_din = 32'h34; expect_wr(5'd3, 32'h34);
    bus.i_id_writes_rd = 1'b1; bus.i_id_rd = 5'd7;
    mid(); chk("waw_stall", 32'(bus.o_stall), 32'd1); nxt();
    bus.i_id_writes_rd = 1'b0; bus.i_wb_din = 32'h35; expect_wr(5'd3, 32'h35);
    mid(); chk("wb_hold_rd", 32'(bus.o_rd), 32'd3); nxt();
    bus.i_wb_rd = 5'd0; bus.i_wb_din = 32'hFFFF;   // write to x0 counts as idle
    expect_wr(5'd7, 32'h7777);
    mid();
    chk("drain_we", 32'(bus.o_reg_write), 32'd1);
    chk("drain_rd", 32'(bus.o_rd), 32'd7);
    chk("drain_din", bus.o_rd_din, 32'h7777);
    nxt();
    idle();

    // Outstanding limit: third issue blocked with no state change.
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd1; nxt();
    bus.i_llu_issue_rd = 5'd2; nxt();
    bus.i_llu_issue = 1'b0;
    mid();
    chk("limit_issue_ready", 32'(bus.o_llu_issue_ready), 32'd0);
    chk("limit_idle_stall", 32'(bus.o_stall), 32'd0);
    nxt();
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd4;
    mid(); chk("blocked_issue_stall", 32'(bus.o_stall), 32'd1); nxt();
    bus.i_llu_issue = 1'b0; bus.i_id_uses_rs1 = 1'b1; bus.i_id_rs1 = 5'd4;
    mid();
    chk("blocked_no_pending", 32'(bus.o_stall), 32'd0);
    chk("blocked_ready", 32'(bus.o_llu_issue_ready), 32'd0);
    nxt();
    bus.i_id_uses_rs1 = 1'b0;
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd1; bus.i_llu_din = 32'h1111;
    expect_wr(5'd1, 32'h1111);
    nxt();
    bus.i_llu_valid = 1'b0;
    mid(); chk("pop_cycle_ready", 32'(bus.o_llu_issue_ready), 32'd0); nxt();
    mid(); chk("after_pop_ready", 32'(bus.o_llu_issue_ready), 32'd1); nxt();
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd2; bus.i_llu_din = 32'h2222;
    expect_wr(5'd2, 32'h2222);
    nxt();
    bus.i_llu_valid = 1'b0; nxt();

    // FIFO full under writeback pressure, then issue+pop and push+pop.
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd10; nxt();
    bus.i_llu_issue_rd = 5'd11;
    mid(); chk("one_out_ready", 32'(bus.o_llu_issue_ready), 32'd1); nxt();
    bus.i_llu_issue = 1'b0;
    bus.i_wb_reg_write = 1'b1; bus.i_wb_rd = 5'd3; bus.i_wb_din = 32'hA0; expect_wr(5'd3, 32'hA0);
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd10; bus.i_llu_din = 32'h1010;
    nxt();
    bus.i_wb_din = 32'hA1; expect_wr(5'd3, 32'hA1);
    bus.i_llu_rd = 5'd11; bus.i_llu_din = 32'h1011;
    nxt();
    bus.i_llu_valid = 1'b0; bus.i_wb_din = 32'hA2; expect_wr(5'd3, 32'hA2);
    mid();
    chk("full_llu_ready", 32'(bus.o_llu_ready), 32'd0);
    chk("full_stall", 32'(bus.o_stall), 32'd1);
    nxt();
    bus.i_wb_reg_write = 1'b0; expect_wr(5'd10, 32'h1010); nxt();
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd12; expect_wr(5'd11, 32'h1011);
    mid(); chk("issue_pop_ready", 32'(bus.o_llu_issue_ready), 32'd1); nxt();
    bus.i_llu_issue_rd = 5'd13;
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd12; bus.i_llu_din = 32'h1212;
    mid(); chk("empty_no_write", 32'(bus.o_reg_write), 32'd0); nxt();
    bus.i_llu_issue = 1'b0;
    bus.i_llu_rd = 5'd13; bus.i_llu_din = 32'h1313; expect_wr(5'd12, 32'h1212);
    mid(); chk("pushpop_llu_ready", 32'(bus.o_llu_ready), 32'd1); nxt();
    bus.i_llu_valid = 1'b0; expect_wr(5'd13, 32'h1313); nxt();
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd20; nxt();
    bus.i_llu_issue = 1'b0;
    mid(); chk("count_balance_ready", 32'(bus.o_llu_issue_ready), 32'd1); nxt();
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd20; bus.i_llu_din = 32'h2020;
    expect_wr(5'd20, 32'h2020);
    nxt();
    bus.i_llu_valid = 1'b0; nxt();

    // rd=0 ops: counted, popped, never written, no error.
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd0; nxt();
    nxt();
    bus.i_llu_issue = 1'b0;
    mid(); chk("rd0_issue_ready", 32'(bus.o_llu_issue_ready), 32'd0); nxt();
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd0; bus.i_llu_din = 32'hAAAA; nxt();
    bus.i_llu_din = 32'hBBBB;
    mid(); chk("rd0_drop_we1", 32'(bus.o_reg_write), 32'd0); nxt();
    bus.i_llu_valid = 1'b0;
    mid(); chk("rd0_drop_we2", 32'(bus.o_reg_write), 32'd0); nxt();
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd23; nxt();
    bus.i_llu_issue = 1'b0;
    mid();
    chk("rd0_count_ready", 32'(bus.o_llu_issue_ready), 32'd1);
    chk("rd0_sb_err", 32'(bus.o_sb_err), 32'd0);
    nxt();
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd23; bus.i_llu_din = 32'h2323;
    expect_wr(5'd23, 32'h2323);
    nxt();
    bus.i_llu_valid = 1'b0; nxt();

    // Reset mid-operation: 2 pending, 1 buffered, writeback busy.
    bus.i_llu_issue = 1'b1; bus.i_llu_issue_rd = 5'd21; nxt();
    bus.i_llu_issue_rd = 5'd22; nxt();
    bus.i_llu_issue = 1'b0;
    bus.i_wb_reg_write = 1'b1; bus.i_wb_rd = 5'd3; bus.i_wb_din = 32'hC0; expect_wr(5'd3, 32'hC0);
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd21; bus.i_llu_din = 32'h2121;
    nxt();
    bus.i_llu_valid = 1'b0; bus.i_wb_din = 32'hC1;
    rst = 1'b1;
    mid();
    chk("mid_rst_we", 32'(bus.o_reg_write), 32'd0);
    chk("mid_rst_stall", 32'(bus.o_stall), 32'd1);
    chk("mid_rst_issue_ready", 32'(bus.o_llu_issue_ready), 32'd0);
    nxt();
    rst = 1'b0;
    bus.i_wb_reg_write = 1'b0;
    bus.i_id_uses_rs1 = 1'b1; bus.i_id_rs1 = 5'd21;
    bus.i_id_uses_rs2 = 1'b1; bus.i_id_rs2 = 5'd22;
    mid();
    chk("rel_stall", 32'(bus.o_stall), 32'd0);
    chk("rel_issue_ready", 32'(bus.o_llu_issue_ready), 32'd1);
    chk("rel_fifo_flushed", 32'(bus.o_reg_write), 32'd0);
    nxt();
    idle();

    // Unissued result sets the sticky error and is still written.
    bus.i_llu_valid = 1'b1; bus.i_llu_rd = 5'd9; bus.i_llu_din = 32'h9999;
    expect_wr(5'd9, 32'h9999);
    nxt();
    bus.i_llu_valid = 1'b0;
    mid(); chk("sb_err_set", 32'(bus.o_sb_err), 32'd1); nxt();
    nxt();
    mid(); chk("sb_err_sticky", 32'(bus.o_sb_err), 32'd1); nxt();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
Shares the single register-file write port between in-order pipeline writeback and a long-latency unit (LLU, e.g. mul/div). A scoreboard tracks registers with outstanding LLU results. The block raises a decode-stage stall on RAW/WAW hazards against those registers. LLU results are buffered in a small FIFO and drained into the write port when pipeline writeback leaves it idle.

Parameters:
XLEN, 32, data width of register values
DEPTH, 2, LLU result FIFO entries and maximum outstanding LLU ops (power of two, >=2)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_wb_reg_write  input  1  pipeline writeback valid
i_wb_rd  input  5  pipeline writeback destination
i_wb_din  input  XLEN  pipeline writeback data
i_llu_issue  input  1  decode dispatches an LLU op this cycle
i_llu_issue_rd  input  5  destination of dispatched LLU op
o_llu_issue_ready  output  1  LLU dispatch may be accepted
i_llu_valid  input  1  LLU result valid
i_llu_rd  input  5  LLU result destination
i_llu_din  input  XLEN  LLU result data
o_llu_ready  output  1  FIFO can accept a result
i_id_rs1  input  5  decode source 1
i_id_rs2  input  5  decode source 2
i_id_rd  input  5  decode destination
i_id_uses_rs1  input  1  decode reads rs1
i_id_uses_rs2  input  1  decode reads rs2
i_id_writes_rd  input  1  decode writes rd
o_stall  output  1  hold decode stage
o_reg_write  output  1  register-file write enable
o_rd  output  5  register-file write address
o_rd_din  output  XLEN  register-file write data
o_sb_err  output  1  sticky: LLU result for a non-pending rd

Behaviour:
- Reset (async on i_rst high): scoreboard = 0, FIFO empty (pointers 0), outstanding count = 0, o_sb_err = 0. While i_rst is high, all outputs are 0, except o_llu_issue_ready = 0 and o_stall = 1. Any op mid-flight is discarded.
- Scoreboard: 32-bit pending vector; bit 0 is never set.
  - Set on accepted issue (i_llu_issue && o_llu_issue_ready) when i_llu_issue_rd != 0.
  - Cleared in the cycle the LLU result for that rd is written to the register file, not when it enters the FIFO.
  - Set and clear of the same bit in the same cycle: set wins.
- Outstanding count (0..DEPTH):
  - +1 per accepted issue, including rd = 0.
  - -1 per FIFO pop.
  - Simultaneous issue and pop: unchanged.
- o_llu_issue_ready = count < DEPTH. An issue without ready is ignored, with no state change.
- FIFO:
  - Push when i_llu_valid && o_llu_ready; o_llu_ready = FIFO not full.
  - Read/write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle are both legal, including when full (pop frees the slot, but o_llu_ready still reflects pre-pop full).
  - A pushed entry is poppable no earlier than the next cycle (minimum result-to-write latency 1 cycle).
- Write port (combinational from state and inputs):
  - WB priority: if i_wb_reg_write && i_wb_rd != 0, drive o_reg_write = 1, o_rd = i_wb_rd, o_rd_din = i_wb_din; no pop.
  - Else if FIFO non-empty: pop head, o_rd/o_rd_din = head, o_reg_write = (head rd != 0). An rd = 0 entry is popped and dropped.
  - Else o_reg_write = 0 and o_rd/o_rd_din = 0.
  - i_wb_reg_write with i_wb_rd = 0 counts as port idle.
- o_stall (combinational) is 1 if any of the following hold:
  - i_id_uses_rs1 and pending[i_id_rs1];
  - i_id_uses_rs2 and pending[i_id_rs2];
  - i_id_writes_rd and pending[i_id_rd] (WAW);
  - i_llu_issue && !o_llu_issue_ready;
  - FIFO full. This injects bubbles so WB eventually idles, preventing starvation.
  - Pending bits for register 0 are always 0.
- Bypass: a source becomes non-pending in the cycle its FIFO pop writes. Decode sees the stall drop in that same cycle and relies on the register file's write-through.
- o_sb_err set on a push whose rd != 0 has pending bit clear; cleared only by reset.

Test Plan:
- Issue LLU rd=5, then decode reads rs1=5 -> o_stall = 1. Push result (5, 0xDEADBEEF) with WB idle -> next cycle o_reg_write = 1, o_rd = 5, o_rd_din = 0xDEADBEEF, pending[5] clears, o_stall = 0 in that cycle.
- Result for rd=7 buffered while WB writes rd=3 for 3 consecutive cycles -> WB rd=3 written each cycle. FIFO holds rd=7 until the first WB-idle cycle, then writes it.
- DEPTH=2: issue rd=1 and rd=2 -> o_llu_issue_ready = 0. A third issue raises o_stall = 1 and changes no state. Pop one result -> ready = 1 the next cycle.
- Fill FIFO (2 results) with WB busy -> o_llu_ready = 0 and o_stall = 1. Push+pop in the same cycle keeps count correct, and pointers wrap after 4 pushes.
- Issue rd=0, push result rd=0 -> popped with o_reg_write = 0, count returns to 0, o_sb_err stays 0. Push rd=9 unissued -> o_sb_err = 1.
- Assert i_rst mid-operation with 2 pending and 1 buffered -> immediately o_reg_write = 0, scoreboard = 0. After release, o_stall = 0 and o_llu_issue_ready = 1.
